// File: rtl/modular_exp_param.sv
// Modular exponentiation engine: result = base^exp_in mod prime.
// Right-to-left square-and-multiply built on interleaved shift-add modular
// multipliers that process one operand bit per clock, MSB first.
//
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active low
//   start   : begin an operation (sampled only while idle)
//   abort   : cancel a running operation (no done pulse)
//   base    : base operand, any value (reduced modulo prime internally)
//   exp_in  : exponent
//   prime   : modulus, must be >= 2
//   result  : last completed result, held until the next done
//   busy    : high while an operation is in flight (including the done cycle)
//   done    : one-cycle completion pulse; result/err valid in that cycle
//   err     : set with done when prime < 2, cleared by the next accepted start
module modular_exp_param #(
  parameter int WIDTH     = 100,
  parameter int EXP_WIDTH = WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     prime,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int R_W   = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    CHECK  = 3'd2,
    MUL    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     p_reg;
  logic [WIDTH-1:0]     acc;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [CNT_W-1:0]     cnt;
  logic [R_W-1:0]       r_a;
  logic [R_W-1:0]       r_b;
  logic [R_W-1:0]       r_a_next;
  logic [R_W-1:0]       r_b_next;
  logic                 last_bit;
  logic                 illegal;

  // One interleaved step: r <- 2r + (sel ? addend : 0), then bring back below p.
  // With r < p and addend < p the sum is below 3p, so two conditional
  // subtractions always suffice and R_W bits never overflow.
  function automatic logic [R_W-1:0] mod_step(
    input logic [R_W-1:0]   r,
    input logic             sel,
    input logic [WIDTH-1:0] addend,
    input logic [WIDTH-1:0] p
  );
    logic [R_W-1:0] t;
    logic [R_W-1:0] pe;
    pe = {2'b00, p};
    t  = (r << 1) + (sel ? {2'b00, addend} : {R_W{1'b0}});
    if (t >= pe) t = t - pe;
    if (t >= pe) t = t - pe;
    return t;
  endfunction

  assign last_bit = (cnt == '0);
  assign illegal  = (p_reg < WIDTH'(2));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Unit A multiplies acc by b_reg. Unit B squares b_reg during MUL and, during
  // REDUCE, computes b_reg*1 so that an unreduced base ends up below p.
  always_comb begin
    r_a_next = mod_step(r_a, acc[cnt], b_reg, p_reg);
    if (state == MUL) r_b_next = mod_step(r_b, b_reg[cnt], b_reg, p_reg);
    else              r_b_next = mod_step(r_b, b_reg[cnt], WIDTH'(1), p_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REDUCE;
      // The modulus is checked on the latched copy, so an illegal modulus
      // costs exactly one cycle before DONE.
      REDUCE: begin
        if (abort)         state_next = IDLE;
        else if (illegal)  state_next = DONE;
        else if (last_bit) state_next = CHECK;
      end
      CHECK: begin
        if (abort)              state_next = IDLE;
        else if (e_reg == '0)   state_next = DONE;
        else                    state_next = MUL;
      end
      MUL: begin
        if (abort)         state_next = IDLE;
        else if (last_bit) state_next = CHECK;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_reg  <= '0;
      p_reg  <= '0;
      acc    <= '0;
      e_reg  <= '0;
      cnt    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_reg <= base;
            e_reg <= exp_in;
            p_reg <= prime;
            acc   <= WIDTH'(1);
            err   <= 1'b0;
            cnt   <= CNT_INIT;
            r_a   <= '0;
            r_b   <= '0;
          end
        end
        REDUCE: begin
          if (!abort) begin
            if (illegal) begin
              result <= '0;
              err    <= 1'b1;
            end else begin
              r_b <= r_b_next;
              cnt <= cnt - CNT_W'(1);
              if (last_bit) b_reg <= r_b_next[WIDTH-1:0];
            end
          end
        end
        CHECK: begin
          if (!abort) begin
            cnt <= CNT_INIT;
            r_a <= '0;
            r_b <= '0;
            if (e_reg == '0) result <= acc;
          end
        end
        MUL: begin
          if (!abort) begin
            r_a <= r_a_next;
            r_b <= r_b_next;
            cnt <= cnt - CNT_W'(1);
            if (last_bit) begin
              if (e_reg[0]) acc <= r_a_next[WIDTH-1:0];
              b_reg <= r_b_next[WIDTH-1:0];
              e_reg <= e_reg >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_exp_param.sv
module tb_modular_exp_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  base;
  logic [8:0]  exp_in;
  logic [7:0]  prime;
  logic [7:0]  result;
  logic        busy;
  logic        done;
  logic        err;

  logic         rst100;
  logic         start100;
  logic         abort100;
  logic [99:0]  base100;
  logic [100:0] exp100;
  logic [99:0]  prime100;
  logic [99:0]  result100;
  logic         busy100;
  logic         done100;
  logic         err100;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modular_exp_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base),
    .exp_in(exp_in), .prime(prime), .result(result), .busy(busy),
    .done(done), .err(err)
  );

  modular_exp_param #(.WIDTH(100)) dut100 (
    .clk(clk), .rst(rst100), .start(start100), .abort(abort100), .base(base100),
    .exp_in(exp100), .prime(prime100), .result(result100), .busy(busy100),
    .done(done100), .err(err100)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic int unsigned ref_modexp(input int unsigned b, input int unsigned e,
                                             input int unsigned p);
    int unsigned r;
    int unsigned sq;
    if (p < 2) return 0;
    r  = 1 % p;
    sq = b % p;
    for (int i = 0; i < 9; i++) begin
      if (((e >> i) & 1) == 1) r = (r * sq) % p;
      sq = (sq * sq) % p;
    end
    return r;
  endfunction

  function automatic int latency8(input int unsigned e, input int unsigned p);
    int k;
    if (p < 2) return 1;
    k = 0;
    for (int i = 0; i < 9; i++) if (((e >> i) & 1) == 1) k = i + 1;
    return (k + 1) * 9;
  endfunction

  // Model state: whether an operation is in flight, edges since acceptance,
  // the edge after which done is due, and the visible result/err.
  bit          m_busy;
  int          m_cnt;
  int          m_n;
  bit          m_ill;
  int unsigned m_res;
  int unsigned m_result;
  bit          m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_cnt = 0; m_n = 0; m_ill = 0; m_res = 0; m_result = 0; m_err = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_cnt  = 0;
        m_err  = 0;
        m_ill  = (prime < 2);
        m_n    = latency8(exp_in, prime);
        m_res  = ref_modexp(base, exp_in, prime);
      end
    end else if (m_cnt == m_n) begin
      m_busy = 0;
    end else if (abort) begin
      m_busy = 0;
    end else begin
      m_cnt++;
      if (m_cnt == m_n) begin
        m_result = m_ill ? 0 : m_res;
        m_err    = m_ill;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("busy", busy, m_busy);
      chk("done", done, (m_busy && m_cnt == m_n));
      chk("result", result, m_result);
      chk("err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  // Runs one operation on the 8-bit engine. abort_at >= 1 makes abort be
  // sampled at that edge; mid_start pulses start again a few cycles in.
  task automatic run_op(input logic [7:0] b, input logic [8:0] e, input logic [7:0] p,
                        input int abort_at, input bit mid_start,
                        output int n, output bit got_done);
    @(negedge clk);
    base = b; exp_in = e; prime = p; start = 1'b1; abort = 1'b0;
    n = -1;
    got_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      start  = (mid_start && i == 5);
      abort  = (abort_at >= 1 && i == abort_at - 1);
      base   = 8'($urandom_range(0, 255));
      exp_in = 9'($urandom_range(0, 511));
      prime  = 8'($urandom_range(0, 255));
      if (done) begin
        n = i;
        got_done = 1;
        break;
      end
      if (abort_at >= 1 && i > abort_at) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (!got_done && abort_at < 1) chk("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    bit gd;
    int unsigned rb, re, rp;
    int ab;

    rst = 1'b0; start = 1'b0; abort = 1'b0; base = '0; exp_in = '0; prime = '0;
    rst100 = 1'b0; start100 = 1'b0; abort100 = 1'b0;
    base100 = '0; exp100 = '0; prime100 = '0;

    // Pin the reference model itself.
    chk("model_5_23_23", ref_modexp(5, 23, 23), 5);
    chk("model_250_1_23", ref_modexp(250, 1, 23), 20);
    chk("model_9_0_23", ref_modexp(9, 0, 23), 1);
    chk("model_2_7_251", ref_modexp(2, 7, 251), 128);
    chk("model_lat_23", latency8(23, 23), 54);

    #3;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1; rst100 = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'd5, 9'd23, 8'd23, -1, 0, n, gd);
    chk("t1_edge", n, 54);
    chk("t1_result", result, 5);
    chk("t1_err", err, 0);
    @(negedge clk);
    chk("t1_pulse_len", done, 0);

    run_op(8'd250, 9'd1, 8'd23, -1, 0, n, gd);
    chk("t2_edge", n, 18);
    chk("t2_result", result, 20);
    run_op(8'd9, 9'd0, 8'd23, -1, 0, n, gd);
    chk("t2b_edge", n, 9);
    chk("t2b_result", result, 1);

    run_op(8'd77, 9'd300, 8'd1, -1, 0, n, gd);
    chk("t3_edge", n, 1);
    chk("t3_err", err, 1);
    chk("t3_result", result, 0);
    run_op(8'd3, 9'd5, 8'd0, -1, 0, n, gd);
    chk("t3b_edge", n, 1);
    chk("t3b_err", err, 1);

    run_op(8'd2, 9'd7, 8'd251, -1, 1, n, gd);
    chk("t4_result", result, 128);
    chk("t4_err_cleared", err, 0);
    chk("t4_edge", n, 36);

    run_op(8'd5, 9'd23, 8'd23, 20, 0, n, gd);
    chk("t5_no_done", gd, 0);
    chk("t5_busy", busy, 0);
    chk("t5_result_held", result, 128);
    run_op(8'd5, 9'd23, 8'd23, -1, 0, n, gd);
    chk("t5_restart_edge", n, 54);
    chk("t5_restart_result", result, 5);

    for (int t = 0; t < 40; t++) begin
      rb = $urandom_range(0, 255);
      re = $urandom_range(0, 511);
      rp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 255);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 90)) : -1;
      run_op(8'(rb), 9'(re), 8'(rp), ab, 0, n, gd);
      if (ab < 1) chk("rand_edge", n, latency8(re, rp));
      repeat (2) @(negedge clk);
    end

    // 100-bit engine.
    @(negedge clk);
    base100 = 100'd5; exp100 = 101'd23; prime100 = 100'd23; start100 = 1'b1;
    n = -1;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      @(negedge clk);
      start100 = 1'b0;
      if (done100) begin n = i; break; end
    end
    chk("w100_edge", n, 606);
    chk("w100_result", result100, 5);
    chk("w100_err", err100, 0);

    repeat (2) @(negedge clk);
    base100 = 100'd7; exp100 = 101'd99; prime100 = 100'd101; start100 = 1'b1;
    @(negedge clk);
    start100 = 1'b0;
    repeat (50) @(negedge clk);
    chk("w100_busy_mid", busy100, 1);
    #2;
    rst100 = 1'b0;
    #1;
    chk("w100_rst_busy", busy100, 0);
    chk("w100_rst_done", done100, 0);
    chk("w100_rst_result", result100, 0);
    chk("w100_rst_err", err100, 0);
    @(negedge clk);
    rst100 = 1'b1;
    gd = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done100) gd = 1;
    end
    chk("w100_no_done_after_rst", gd, 0);
    chk("w100_idle_after_rst", busy100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
